// File: rtl/axi_burst_gen.sv
// -----------------------------------------------------------------------------
// axi_burst_gen
//
// Splits one DMA transfer command (start byte address + bytes-to-transfer) into
// a sequence of AXI4 INCR address-channel requests. Each burst is limited to
// MAX_BURST_LEN beats and never crosses a BOUNDARY-byte address boundary. For
// every burst the strobes of its first and last data beat are supplied so the
// data mover can mask partial beats at unaligned ends.
//
// Ports:
//   aclk, areset      clock and synchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_addr = start byte address,
//                     cmd_btt = bytes to transfer (0 is reported as an error)
//   ax_valid/ready    burst request handshake towards the AXI master
//   ax_addr, ax_len   burst start address and beats-1
//   ax_size, ax_burst constant beat size (log2 BYTE_LANES) and INCR type
//   ax_first_strb     byte strobe of the first beat of the burst
//   ax_last_strb      byte strobe of the last beat of the burst
//   busy              high whenever a command is in progress
//   done, err         one-cycle completion pulse; err marks a zero-length command
// -----------------------------------------------------------------------------
module axi_burst_gen #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int BYTE_LANES    = DATA_WIDTH / 8,
   parameter int MAX_BURST_LEN = 16,
   parameter int LEN_WIDTH     = 26,
   parameter int BOUNDARY      = 4096
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_btt,
   output logic                  ax_valid,
   input  logic                  ax_ready,
   output logic [ADDR_WIDTH-1:0] ax_addr,
   output logic [7:0]            ax_len,
   output logic [2:0]            ax_size,
   output logic [1:0]            ax_burst,
   output logic [BYTE_LANES-1:0] ax_first_strb,
   output logic [BYTE_LANES-1:0] ax_last_strb,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int SIZE  = $clog2(BYTE_LANES);
   localparam int BND_W = $clog2(BOUNDARY);
   // Arithmetic width: wide enough for off+rem+lanes and for BOUNDARY itself.
   localparam int CW    = ((LEN_WIDTH > BND_W) ? LEN_WIDTH : BND_W) + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      ISSUE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q;
   logic [LEN_WIDTH-1:0]  rem_q;
   logic [LEN_WIDTH-1:0]  cons_q;     // bytes covered by the burst being issued
   logic                  err_q;
   logic                  cmd_ready_q;

   // Burst geometry for the current address/remainder, consumed in CALC.
   logic [CW-1:0]         off_w, rem_w, tot, bnd, beats, span, cons_w, end_w;
   logic [BND_W-1:0]      al_mod;
   logic [BYTE_LANES-1:0] first_strb_d, last_strb_d;

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is always updated with non-blocking assignments so
   // every flop samples the pre-edge values of the others, independent of
   // process ordering in simulation.
   always_ff @(posedge aclk) begin
      if (areset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------------
   // NOTE: every variable of an always_comb gets a default first; a path that
   // leaves one unassigned would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cmd_valid && cmd_ready_q)
                     state_d = (cmd_btt == '0) ? DONE : CALC;
         CALC:    state_d = ISSUE;
         ISSUE:   if (ax_ready)
                     state_d = (rem_q == cons_q) ? DONE : CALC;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Burst geometry
   // ---------------------------------------------------------------------------
   always_comb begin
      off_w  = CW'(cur_addr_q & ADDR_WIDTH'(BYTE_LANES - 1));
      rem_w  = CW'(rem_q);
      // Beat-aligned address modulo BOUNDARY gives the room left before the
      // boundary; the low lane bits are cleared so partial first beats count
      // as a whole beat.
      al_mod = BND_W'(cur_addr_q) & ~BND_W'(BYTE_LANES - 1);
      tot    = (off_w + rem_w + CW'(BYTE_LANES - 1)) >> SIZE;
      bnd    = (CW'(BOUNDARY) - CW'(al_mod)) >> SIZE;

      beats = tot;
      if (CW'(MAX_BURST_LEN) < beats) beats = CW'(MAX_BURST_LEN);
      if (bnd < beats)                beats = bnd;

      // Bytes actually moved: the burst span minus the leading skipped lanes,
      // unless the command ends inside the burst.
      span   = (beats << SIZE) - off_w;
      cons_w = (span < rem_w) ? span : rem_w;
      end_w  = (off_w + cons_w) & CW'(BYTE_LANES - 1);

      first_strb_d = '0;
      last_strb_d  = '0;
      for (int i = 0; i < BYTE_LANES; i++) begin
         first_strb_d[i] = (CW'(i) >= off_w);
         last_strb_d[i]  = (end_w == '0) || (CW'(i) < end_w);
      end
      // A single-beat burst is both first and last beat.
      if (beats == CW'(1)) begin
         first_strb_d = first_strb_d & last_strb_d;
         last_strb_d  = first_strb_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         cur_addr_q    <= '0;
         rem_q         <= '0;
         cons_q        <= '0;
         err_q         <= 1'b0;
         cmd_ready_q   <= 1'b0;
         ax_addr       <= '0;
         ax_len        <= '0;
         ax_first_strb <= '0;
         ax_last_strb  <= '0;
      end else begin
         // Ready is registered so it stays low through the reset cycle and
         // rises on the first edge after release.
         cmd_ready_q <= (state_d == IDLE);
         unique case (state_q)
            IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  cur_addr_q <= cmd_addr;
                  rem_q      <= cmd_btt;
                  err_q      <= (cmd_btt == '0);
               end
            end
            CALC: begin
               ax_addr       <= cur_addr_q;
               ax_len        <= 8'(beats - CW'(1));
               ax_first_strb <= first_strb_d;
               ax_last_strb  <= last_strb_d;
               cons_q        <= LEN_WIDTH'(cons_w);
            end
            ISSUE: begin
               if (ax_ready) begin
                  cur_addr_q <= cur_addr_q + ADDR_WIDTH'(cons_q);
                  rem_q      <= rem_q - cons_q;
               end
            end
            DONE: err_q <= 1'b0;
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign cmd_ready = cmd_ready_q;
   assign ax_valid  = (state_q == ISSUE);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign err       = (state_q == DONE) && err_q;
   assign ax_size   = 3'(SIZE);
   assign ax_burst  = 2'b01;

endmodule

// File: tb/tb_axi_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_axi_burst_gen
//
// Directed bench for axi_burst_gen with its default parameters (32-bit data,
// 16-beat bursts, 4 KB boundary). Each scenario task drives a command, follows
// the burst handshakes and compares outputs against hand-computed values.
// Outputs are sampled 1 ns after the rising edge; inputs change at that point.
// -----------------------------------------------------------------------------
module tb_axi_burst_gen;

   logic        aclk = 1'b0;
   logic        areset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [25:0] cmd_btt;
   logic        ax_valid;
   logic        ax_ready;
   logic [31:0] ax_addr;
   logic [7:0]  ax_len;
   logic [2:0]  ax_size;
   logic [1:0]  ax_burst;
   logic [3:0]  ax_first_strb;
   logic [3:0]  ax_last_strb;
   logic        busy;
   logic        done;
   logic        err;

   int checks   = 0;
   int failures = 0;

   axi_burst_gen dut (
      .aclk          (aclk),
      .areset        (areset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_addr      (cmd_addr),
      .cmd_btt       (cmd_btt),
      .ax_valid      (ax_valid),
      .ax_ready      (ax_ready),
      .ax_addr       (ax_addr),
      .ax_len        (ax_len),
      .ax_size       (ax_size),
      .ax_burst      (ax_burst),
      .ax_first_strb (ax_first_strb),
      .ax_last_strb  (ax_last_strb),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   always #5 aclk = ~aclk;

   // ---------------------------------------------------------------------------
   // Stimulus helpers (no comparisons inside)
   // ---------------------------------------------------------------------------
   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   // Present a command for one cycle; returns in the cycle after the handshake.
   task automatic send_cmd(input logic [31:0] addr, input logic [25:0] btt);
      cmd_addr  = addr;
      cmd_btt   = btt;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   // Advance until ax_valid is seen, bounded; waited = cycles advanced.
   task automatic wait_ax(output int waited);
      waited = 0;
      while (!ax_valid && waited < 20) begin
         step();
         waited++;
      end
   endtask

   task automatic accept_ax();
      ax_ready = 1'b1;
      step();
      ax_ready = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      areset    = 1'b1;
      cmd_valid = 1'b0;
      ax_ready  = 1'b0;
      cmd_addr  = '0;
      cmd_btt   = '0;
      repeat (3) step();
      checks++;
      if ({cmd_ready, ax_valid, busy, done, err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got rdy/axv/busy/done/err=%b expected 00000",
                  {cmd_ready, ax_valid, busy, done, err});
      end
      checks++;
      if ({ax_addr, ax_len, ax_first_strb, ax_last_strb} !== 48'h0) begin
         failures++;
         $display("FAIL reset_ax: got addr=%h len=%0d fs=%b ls=%b expected zeros",
                  ax_addr, ax_len, ax_first_strb, ax_last_strb);
      end
      checks++;
      if (ax_size !== 3'd2 || ax_burst !== 2'b01) begin
         failures++;
         $display("FAIL reset_const: got size=%0d burst=%b expected 2/01", ax_size, ax_burst);
      end
      areset = 1'b0;
      step();
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got cmd_ready=%b busy=%b expected 1/0", cmd_ready, busy);
      end
   endtask

   // addr 0x0, btt 64 -> single 16-beat burst
   task automatic test_single_burst();
      int waited;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL single_ready: got cmd_ready=%b expected 1", cmd_ready);
      end
      send_cmd(32'h0, 26'd64);
      checks++;
      if (busy !== 1'b1 || ax_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL single_calc: got busy=%b ax_valid=%b cmd_ready=%b expected 1/0/0",
                  busy, ax_valid, cmd_ready);
      end
      wait_ax(waited);
      checks++;
      if (waited != 1) begin
         failures++;
         $display("FAIL single_latency: got %0d cycles to ax_valid expected 1", waited);
      end
      checks++;
      if ({ax_addr, ax_len, ax_size, ax_burst, ax_first_strb, ax_last_strb} !==
          {32'h0, 8'd15, 3'd2, 2'b01, 4'hF, 4'hF}) begin
         failures++;
         $display("FAIL single_burst: got addr=%h len=%0d size=%0d burst=%b fs=%b ls=%b expected 0/15/2/01/1111/1111",
                  ax_addr, ax_len, ax_size, ax_burst, ax_first_strb, ax_last_strb);
      end
      accept_ax();
      checks++;
      if ({done, err, ax_valid, busy} !== 4'b1001) begin
         failures++;
         $display("FAIL single_done: got done/err/axv/busy=%b expected 1001",
                  {done, err, ax_valid, busy});
      end
      step();
      checks++;
      if ({done, busy, cmd_ready} !== 3'b001) begin
         failures++;
         $display("FAIL single_idle: got done/busy/cmd_ready=%b expected 001",
                  {done, busy, cmd_ready});
      end
   endtask

   // addr 0xFF0, btt 64 -> split at the 4 KB boundary
   task automatic test_boundary_split();
      logic [31:0] exp_addr [2] = '{32'hFF0, 32'h1000};
      logic [7:0]  exp_len  [2] = '{8'd3, 8'd11};
      int waited;
      int done_seen = 0;
      send_cmd(32'hFF0, 26'd64);
      for (int b = 0; b < 2; b++) begin
         wait_ax(waited);
         checks++;
         if (waited != 1 || {ax_addr, ax_len, ax_first_strb, ax_last_strb} !==
             {exp_addr[b], exp_len[b], 4'hF, 4'hF}) begin
            failures++;
            $display("FAIL split_burst%0d: got wait=%0d addr=%h len=%0d fs=%b ls=%b expected 1/%h/%0d/1111/1111",
                     b, waited, ax_addr, ax_len, ax_first_strb, ax_last_strb, exp_addr[b], exp_len[b]);
         end
         accept_ax();
         if (done) done_seen++;
      end
      step();
      if (done) done_seen++;
      checks++;
      if (done_seen != 1) begin
         failures++;
         $display("FAIL split_done: got %0d done pulses expected 1", done_seen);
      end
   endtask

   // Unaligned starts and ends
   task automatic test_unaligned();
      int waited;
      send_cmd(32'h2, 26'd7);
      wait_ax(waited);
      checks++;
      if ({ax_addr, ax_len, ax_first_strb, ax_last_strb} !== {32'h2, 8'd2, 4'b1100, 4'b0001}) begin
         failures++;
         $display("FAIL unaligned_a: got addr=%h len=%0d fs=%b ls=%b expected 2/2/1100/0001",
                  ax_addr, ax_len, ax_first_strb, ax_last_strb);
      end
      accept_ax();
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL unaligned_a_done: got done=%b expected 1", done);
      end
      step();
      send_cmd(32'h1, 26'd2);
      wait_ax(waited);
      checks++;
      if ({ax_addr, ax_len, ax_first_strb, ax_last_strb} !== {32'h1, 8'd0, 4'b0110, 4'b0110}) begin
         failures++;
         $display("FAIL unaligned_b: got addr=%h len=%0d fs=%b ls=%b expected 1/0/0110/0110",
                  ax_addr, ax_len, ax_first_strb, ax_last_strb);
      end
      accept_ax();
      step();
   endtask

   // addr 0x100, btt 200 -> three full bursts and a 2-beat tail
   task automatic test_multi_burst();
      logic [31:0] exp_addr [4] = '{32'h100, 32'h140, 32'h180, 32'h1C0};
      logic [7:0]  exp_len  [4] = '{8'd15, 8'd15, 8'd15, 8'd1};
      int waited;
      send_cmd(32'h100, 26'd200);
      for (int b = 0; b < 4; b++) begin
         wait_ax(waited);
         checks++;
         if (waited != 1 || {ax_addr, ax_len, ax_first_strb, ax_last_strb} !==
             {exp_addr[b], exp_len[b], 4'hF, 4'hF}) begin
            failures++;
            $display("FAIL multi_burst%0d: got wait=%0d addr=%h len=%0d fs=%b ls=%b expected 1/%h/%0d/1111/1111",
                     b, waited, ax_addr, ax_len, ax_first_strb, ax_last_strb, exp_addr[b], exp_len[b]);
         end
         accept_ax();
         checks++;
         if (done !== (b == 3)) begin
            failures++;
            $display("FAIL multi_done%0d: got done=%b expected %b", b, done, (b == 3));
         end
      end
      step();
   endtask

   // btt 0 -> done+err one cycle after accept, no burst
   task automatic test_zero_length();
      send_cmd(32'h40, 26'd0);
      checks++;
      if ({done, err, ax_valid, cmd_ready, busy} !== 5'b11001) begin
         failures++;
         $display("FAIL zero_done: got done/err/axv/rdy/busy=%b expected 11001",
                  {done, err, ax_valid, cmd_ready, busy});
      end
      step();
      checks++;
      if ({done, err, ax_valid, cmd_ready, busy} !== 5'b00010) begin
         failures++;
         $display("FAIL zero_idle: got done/err/axv/rdy/busy=%b expected 00010",
                  {done, err, ax_valid, cmd_ready, busy});
      end
   endtask

   // ax_ready held low 5 cycles; a stray command meanwhile must be ignored
   task automatic test_backpressure();
      int waited;
      int unstable = 0;
      send_cmd(32'h0, 26'd64);
      wait_ax(waited);
      cmd_addr  = 32'h800;
      cmd_btt   = 26'd4;
      cmd_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         if (ax_valid !== 1'b1 || cmd_ready !== 1'b0 ||
             {ax_addr, ax_len, ax_first_strb, ax_last_strb} !== {32'h0, 8'd15, 4'hF, 4'hF})
            unstable++;
      end
      cmd_valid = 1'b0;
      checks++;
      if (unstable != 0) begin
         failures++;
         $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", unstable);
      end
      accept_ax();
      checks++;
      if ({done, ax_valid} !== 2'b10) begin
         failures++;
         $display("FAIL backpressure_done: got done/axv=%b expected 10", {done, ax_valid});
      end
      step();
   endtask

   // areset during ISSUE aborts without a done pulse
   task automatic test_reset_mid_issue();
      int waited;
      int done_seen = 0;
      send_cmd(32'h200, 26'd64);
      wait_ax(waited);
      areset = 1'b1;
      step();
      checks++;
      if ({ax_valid, busy, done, cmd_ready} !== 4'b0000) begin
         failures++;
         $display("FAIL abort_edge: got axv/busy/done/rdy=%b expected 0000",
                  {ax_valid, busy, done, cmd_ready});
      end
      areset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (done || ax_valid) done_seen++;
      end
      checks++;
      if (done_seen != 0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_quiet: got %0d done/axv cycles, cmd_ready=%b expected 0/1",
                  done_seen, cmd_ready);
      end
      test_single_burst();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_burst();
      test_boundary_split();
      test_unaligned();
      test_multi_burst();
      test_zero_length();
      test_backpressure();
      test_reset_mid_issue();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
